light_timer: RTL and testbench

Phase timer for the highway traffic-light path. It watches the highway controller's one-hot lamp output and restarts a per-phase countdown on every lamp change. It drives the controller's `time_out` input once the active phase has lasted its programmed duration. Each duration is a number of seconds, and one second is `CLK_DIV` clocks from an internal prescaler.

---
 rtl/light_timer.sv | 83 ++++++++
 tb/tb_light_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/light_timer.sv
// light_timer
//   Phase timer for the highway traffic-light path. Watches the controller's
//   one-hot lamp pattern, reloads a per-phase countdown on every lamp change
//   and raises time_out once the active phase has lasted its duration.
//   One second is CLK_DIV clocks of an internal prescaler.
//
// Ports
//   clk        in   single clock, rising-edge active
//   rst        in   synchronous active-high reset
//   hw_led     in   [2:0] lamp pattern: 100 green, 010 yellow, 001 red
//   time_out   out  phase duration elapsed (level)
//   remaining  out  [W-1:0] whole seconds left in the current phase
//   phase_err  out  hw_led is not one of the three legal patterns
module light_timer #(
  parameter int CLK_DIV  = 50_000_000,
  parameter int PW       = 26,
  parameter int W        = 8,
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 3,
  parameter int RED_T    = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   hw_led,
  output logic         time_out,
  output logic [W-1:0] remaining,
  output logic         phase_err
);

  localparam logic [PW-1:0] PRE_RELOAD = PW'(CLK_DIV - 1);
  localparam logic [2:0]    LED_GREEN  = 3'b100;
  localparam logic [2:0]    LED_YELLOW = 3'b010;
  localparam logic [2:0]    LED_RED    = 3'b001;

  logic [2:0]    led_q;
  logic [PW-1:0] pre;
  logic [W-1:0]  cnt;

  logic          legal;
  logic          changed;
  logic [W-1:0]  dur;

  always_comb begin
    legal = 1'b0;
    dur   = W'(GREEN_T);
    case (hw_led)
      LED_GREEN:  begin legal = 1'b1; dur = W'(GREEN_T);  end
      LED_YELLOW: begin legal = 1'b1; dur = W'(YELLOW_T); end
      LED_RED:    begin legal = 1'b1; dur = W'(RED_T);    end
      default:    ;
    endcase
  end

  assign changed = legal && (hw_led != led_q);

  // Illegal patterns freeze everything; the countdown resumes untouched if
  // the controller comes back to the same lamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= LED_GREEN;
      cnt   <= W'(GREEN_T);
      pre   <= PRE_RELOAD;
    end else if (changed) begin
      led_q <= hw_led;
      cnt   <= dur;
      pre   <= PRE_RELOAD;
    end else if (legal) begin
      if (pre != '0) begin
        pre <= pre - PW'(1);
      end else begin
        pre <= PRE_RELOAD;
        if (cnt != '0) cnt <= cnt - W'(1);
      end
    end
  end

  // Gating with hw_led == led_q forces time_out low in the very cycle the
  // controller switches lamps, so it can never advance twice.
  assign time_out  = legal && (hw_led == led_q) && (cnt == '0);
  assign remaining = cnt;
  assign phase_err = !legal;

endmodule

// File: tb/tb_light_timer.sv
// tb_light_timer
//   Directed scenarios plus randomized lamp sequences for light_timer, checked
//   every cycle against a reference model that tracks elapsed counting cycles
//   since the last phase load and derives remaining seconds by division.
module tb_light_timer;

  localparam int CLK_DIV  = 4;
  localparam int PW       = 4;
  localparam int W        = 8;
  localparam int GREEN_T  = 3;
  localparam int YELLOW_T = 1;
  localparam int RED_T    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   hw_led;
  logic         time_out;
  logic [W-1:0] remaining;
  logic         phase_err;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [2:0] m_led;
  int         m_el;
  int         m_t;
  logic       last_exp_to;

  light_timer #(
    .CLK_DIV(CLK_DIV), .PW(PW), .W(W),
    .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .RED_T(RED_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hw_led(hw_led),
    .time_out(time_out),
    .remaining(remaining),
    .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [2:0] h);
    return (h == 3'b100) || (h == 3'b010) || (h == 3'b001);
  endfunction

  function automatic int dur_of(input logic [2:0] h);
    if (h == 3'b100) return GREEN_T;
    if (h == 3'b010) return YELLOW_T;
    return RED_T;
  endfunction

  function automatic int model_rem();
    int secs;
    secs = m_el / CLK_DIV;
    return (secs >= m_t) ? 0 : m_t - secs;
  endfunction

  function automatic logic [2:0] next_lamp(input logic [2:0] h);
    if (h == 3'b100) return 3'b010;
    if (h == 3'b010) return 3'b001;
    return 3'b100;
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] h);
    if (r) begin
      m_led = 3'b100; m_el = 0; m_t = GREEN_T;
    end else if (is_legal(h)) begin
      if (h != m_led) begin
        m_led = h; m_el = 0; m_t = dur_of(h);
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic check_now();
    logic [W-1:0] exp_rem;
    logic         exp_to;
    logic         exp_err;
    exp_rem = W'(model_rem());
    exp_err = !is_legal(hw_led);
    exp_to  = is_legal(hw_led) && (hw_led == m_led) && (model_rem() == 0);
    last_exp_to = exp_to;
    vectors += 3;
    assert (remaining === exp_rem) else begin
      miscompares++;
      $error("FAIL remaining t=%0t got %0d want %0d", $time, remaining, exp_rem);
    end
    assert (time_out === exp_to) else begin
      miscompares++;
      $error("FAIL time_out t=%0t hw=%b got %b want %b", $time, hw_led, time_out, exp_to);
    end
    assert (phase_err === exp_err) else begin
      miscompares++;
      $error("FAIL phase_err t=%0t hw=%b got %b want %b", $time, hw_led, phase_err, exp_err);
    end
  endtask

  task automatic expect_rem(input string tag, input int want);
    vectors++;
    assert (remaining === W'(want)) else begin
      miscompares++;
      $error("FAIL %s got %0d want %0d", tag, remaining, want);
    end
  endtask

  // Drive one cycle: set inputs shortly after an edge, check mid-cycle,
  // then advance the model across the next rising edge.
  task automatic step(input logic r, input logic [2:0] h);
    rst = r;
    hw_led = h;
    #2;
    check_now();
    @(posedge clk);
    model_edge(r, h);
    #1;
  endtask

  initial begin
    logic [2:0] lamp;
    logic [2:0] pat;
    logic [2:0] bad [5];
    int hold;
    int pick;
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101;
    bad[3] = 3'b110; bad[4] = 3'b111;

    rst = 1'b1;
    hw_led = 3'b100;
    @(posedge clk);
    model_edge(1'b1, 3'b100);
    #1;

    // reset, green held
    step(1'b1, 3'b100);
    expect_rem("reset_green", GREEN_T);
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, 3'b100);
      if (i == 4)  expect_rem("green_e4", 2);
      if (i == 8)  expect_rem("green_e8", 1);
      if (i == 12) expect_rem("green_e12", 0);
    end

    // full cycle with a model controller, sensor from edge 20
    step(1'b1, 3'b100);
    lamp = 3'b100;
    for (int c = 1; c <= 60; c++) begin
      step(1'b0, lamp);
      if (last_exp_to && (lamp != 3'b100 || c >= 20)) lamp = next_lamp(lamp);
    end

    // early lamp change at edge 6
    step(1'b1, 3'b100);
    repeat (5) step(1'b0, 3'b100);
    step(1'b0, 3'b010);
    expect_rem("early_reload", YELLOW_T);
    repeat (6) step(1'b0, 3'b010);

    // illegal pattern mid-yellow, then resume
    step(1'b1, 3'b100);
    step(1'b0, 3'b010);
    repeat (2) step(1'b0, 3'b010);
    repeat (10) step(1'b0, 3'b110);
    repeat (6) step(1'b0, 3'b010);

    // reset during red with one second left
    step(1'b1, 3'b100);
    step(1'b0, 3'b001);
    repeat (4) step(1'b0, 3'b001);
    expect_rem("red_before_rst", 1);
    step(1'b1, 3'b001);
    expect_rem("red_after_rst", GREEN_T);
    repeat (6) step(1'b0, 3'b100);

    // reset coincident with a lamp change
    step(1'b1, 3'b100);
    repeat (2) step(1'b0, 3'b100);
    step(1'b1, 3'b010);
    expect_rem("simul_rst", GREEN_T);
    step(1'b0, 3'b010);
    expect_rem("simul_next", YELLOW_T);

    // randomized lamp sequences with occasional illegal patterns and resets
    for (int n = 0; n < 120; n++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 3)      pat = 3'b100;
      else if (pick < 6) pat = 3'b010;
      else if (pick < 9) pat = 3'b001;
      else               pat = bad[$urandom_range(0, 4)];
      hold = int'($urandom_range(1, 14));
      for (int k = 0; k < hold; k++)
        step(($urandom_range(0, 59) == 0), pat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
